// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Synchronises N_CH asynchronous level inputs and detects their rising edges.
// Each edge is held as a one-deep pending flag per channel. A round-robin
// scheduler drains the pending flags one at a time onto a valid/ready port.
// Sticky per-channel overrun flags record edges lost to a full pending slot.
module edge_event_arbiter #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          sig_in,
  input  logic                     evt_ready,
  input  logic                     clear_ovr,
  output logic                     evt_valid,
  output logic [$clog2(N_CH)-1:0]  evt_ch,
  output logic [N_CH-1:0]          pending,
  output logic [N_CH-1:0]          ovr
);

  localparam int CH_W = $clog2(N_CH);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Synchroniser chain, previous-sample register and edge detect
  logic [N_CH-1:0] sync_r [SYNC_STAGES];
  logic [N_CH-1:0] sync_out_s;
  logic [N_CH-1:0] prev_r;
  logic [N_CH-1:0] rise_s;

  // Event bookkeeping
  logic [N_CH-1:0] pending_r;
  logic [N_CH-1:0] pending_nxt_s;
  logic [N_CH-1:0] ovr_r;
  logic [N_CH-1:0] ovr_set_s;
  logic [N_CH-1:0] ovr_nxt_s;
  logic [N_CH-1:0] load_mask_s;

  // Scheduler
  logic [CH_W-1:0] rr_ptr_r;
  logic [CH_W-1:0] sel_s;
  logic            found_s;
  int              idx_s;
  logic            load_s;
  state_t          state_r;
  state_t          state_nxt_s;
  logic            evt_valid_r;
  logic [CH_W-1:0] evt_ch_r;

  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign rise_s     = sync_out_s & ~prev_r;

  // Shift the raw inputs through the synchroniser flops and keep the last synced sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {N_CH{1'b0}};
      end
      prev_r <= {N_CH{1'b0}};
    end else begin
      sync_r[0] <= sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
      prev_r <= sync_out_s;
    end
  end

  // Round-robin search: first registered pending bit after rr_ptr, wrapping to 0
  always_comb begin
    sel_s   = rr_ptr_r;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx_s = (int'(rr_ptr_r) + k) % N_CH;
      if (!found_s && pending_r[idx_s]) begin
        sel_s   = CH_W'(idx_s);
        found_s = 1'b1;
      end else begin
        sel_s   = sel_s;
        found_s = found_s;
      end
    end
  end

  // Next-state and load decision for the presentation FSM
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (|pending_r) begin
          load_s      = 1'b1;
          state_nxt_s = PRESENT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          if (|pending_r) begin
            load_s      = 1'b1;
            state_nxt_s = PRESENT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Pending and overrun update: a load frees the slot, a rise fills it, a rise into a full slot overruns
  always_comb begin
    load_mask_s = {N_CH{1'b0}};
    if (load_s) begin
      load_mask_s[sel_s] = 1'b1;
    end else begin
      load_mask_s = {N_CH{1'b0}};
    end
    pending_nxt_s = (pending_r & ~load_mask_s) | rise_s;
    ovr_set_s     = rise_s & pending_r & ~load_mask_s;
    if (clear_ovr) begin
      ovr_nxt_s = ovr_set_s;
    end else begin
      ovr_nxt_s = ovr_r | ovr_set_s;
    end
  end

  // State, round-robin pointer, flags and registered event outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= CH_W'(N_CH - 1);
      pending_r   <= {N_CH{1'b0}};
      ovr_r       <= {N_CH{1'b0}};
      evt_valid_r <= 1'b0;
      evt_ch_r    <= {CH_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      pending_r   <= pending_nxt_s;
      ovr_r       <= ovr_nxt_s;
      evt_valid_r <= (state_nxt_s == PRESENT);
      if (load_s) begin
        rr_ptr_r <= sel_s;
        evt_ch_r <= sel_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
        evt_ch_r <= evt_ch_r;
      end
    end
  end

  assign evt_valid = evt_valid_r;
  assign evt_ch    = evt_ch_r;
  assign pending   = pending_r;
  assign ovr       = ovr_r;

endmodule
